sram_sp_arb: RTL and testbench

- Shares one single-port, byte-enable, synchronous-read SRAM macro between two requesters.
- Port A is the read-only instruction-fetch side. Port B is the data side and issues reads and byte-masked writes.
- Arbitrates one SRAM access per cycle, sequences the 1-cycle read latency, and returns per-port responses through valid/ready handshakes.
- Sits between the core's fetch and LSU interfaces and the sram_sp_be instance.

---
 rtl/sram_sp_arb.sv | 125 ++++++++++++
 tb/tb_sram_sp_arb.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/sram_sp_arb.sv
// Two-port arbiter in front of a single-port byte-enable SRAM with 1-cycle read latency.
// Define SRAM_SP_ARB_RR_EN for round-robin arbitration; default is fixed priority, B over A.
module sram_sp_arb #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1024,
    localparam int AW = $clog2(DEPTH),
    localparam int BW = WIDTH / 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_req_val,
    output logic             a_req_rdy,
    input  logic [AW-1:0]    a_req_addr,
    output logic             a_rsp_val,
    input  logic             a_rsp_rdy,
    output logic [WIDTH-1:0] a_rsp_data,
    input  logic             b_req_val,
    output logic             b_req_rdy,
    input  logic             b_req_we,
    input  logic [BW-1:0]    b_req_be,
    input  logic [AW-1:0]    b_req_addr,
    input  logic [WIDTH-1:0] b_req_data,
    output logic             b_rsp_val,
    input  logic             b_rsp_rdy,
    output logic [WIDTH-1:0] b_rsp_data,
    output logic             sram_en,
    output logic             sram_we,
    output logic [BW-1:0]    sram_wbe,
    output logic [AW-1:0]    sram_addr,
    output logic [WIDTH-1:0] sram_di,
    input  logic [WIDTH-1:0] sram_do
);

    logic             pend_a_q, pend_a_d;
    logic             pend_b_q, pend_b_d;
    logic             pend_we_b_q, pend_we_b_d;
    logic             hold_val_a_q, hold_val_a_d;
    logic             hold_val_b_q, hold_val_b_d;
    logic [WIDTH-1:0] hold_data_a_q, hold_data_a_d;
    logic [WIDTH-1:0] hold_data_b_q, hold_data_b_d;
    logic             elig_a, elig_b;
    logic             grant_a, grant_b;
    logic [WIDTH-1:0] b_direct;
`ifdef SRAM_SP_ARB_RR_EN
    logic             last_b_q, last_b_d;
`endif

    // A port may issue only if its previous response is not going to be parked this cycle.
    always_comb begin
        elig_a  = a_req_val & ~hold_val_a_q & ~(pend_a_q & ~a_rsp_rdy);
        elig_b  = b_req_val & ~hold_val_b_q & ~(pend_b_q & ~b_rsp_rdy);
        grant_b = elig_b;
        grant_a = elig_a & ~elig_b;
`ifdef SRAM_SP_ARB_RR_EN
        if (elig_a && elig_b) begin
            grant_b = ~last_b_q;
            grant_a = last_b_q;
        end
`endif
        if (!rst_n) begin
            grant_a = 1'b0;
            grant_b = 1'b0;
        end
    end

    always_comb begin
        a_req_rdy = grant_a;
        b_req_rdy = grant_b;
        sram_en   = grant_a | grant_b;
        sram_we   = grant_b & b_req_we;
        sram_wbe  = sram_we ? b_req_be : '0;
        sram_addr = grant_b ? b_req_addr : (grant_a ? a_req_addr : '0);
        sram_di   = grant_b ? b_req_data : '0;
    end

    // Write acks carry zero data; held data always wins over the live SRAM output.
    always_comb begin
        b_direct   = pend_we_b_q ? '0 : sram_do;
        a_rsp_val  = pend_a_q | hold_val_a_q;
        b_rsp_val  = pend_b_q | hold_val_b_q;
        a_rsp_data = hold_val_a_q ? hold_data_a_q : (pend_a_q ? sram_do : '0);
        b_rsp_data = hold_val_b_q ? hold_data_b_q : (pend_b_q ? b_direct : '0);
    end

    always_comb begin
        pend_a_d      = grant_a;
        pend_b_d      = grant_b;
        pend_we_b_d   = grant_b & b_req_we;
        hold_val_a_d  = hold_val_a_q ? ~a_rsp_rdy : (pend_a_q & ~a_rsp_rdy);
        hold_val_b_d  = hold_val_b_q ? ~b_rsp_rdy : (pend_b_q & ~b_rsp_rdy);
        hold_data_a_d = (pend_a_q & ~hold_val_a_q & ~a_rsp_rdy) ? sram_do : hold_data_a_q;
        hold_data_b_d = (pend_b_q & ~hold_val_b_q & ~b_rsp_rdy) ? b_direct : hold_data_b_q;
`ifdef SRAM_SP_ARB_RR_EN
        last_b_d      = (grant_a | grant_b) ? grant_b : last_b_q;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_a_q      <= 1'b0;
            pend_b_q      <= 1'b0;
            pend_we_b_q   <= 1'b0;
            hold_val_a_q  <= 1'b0;
            hold_val_b_q  <= 1'b0;
            hold_data_a_q <= '0;
            hold_data_b_q <= '0;
        end else begin
            pend_a_q      <= pend_a_d;
            pend_b_q      <= pend_b_d;
            pend_we_b_q   <= pend_we_b_d;
            hold_val_a_q  <= hold_val_a_d;
            hold_val_b_q  <= hold_val_b_d;
            hold_data_a_q <= hold_data_a_d;
            hold_data_b_q <= hold_data_b_d;
        end
    end

`ifdef SRAM_SP_ARB_RR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_b_q <= 1'b0;
        else        last_b_q <= last_b_d;
    end
`endif

endmodule

// File: tb/tb_sram_sp_arb.sv
// Directed bench for sram_sp_arb with a behavioural read-first byte-enable SRAM attached.
module tb_sram_sp_arb;
    localparam int WIDTH = 32;
    localparam int DEPTH = 64;
    localparam int AW = 6;
    localparam int BW = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             a_req_val, a_req_rdy, a_rsp_val, a_rsp_rdy;
    logic [AW-1:0]    a_req_addr;
    logic [WIDTH-1:0] a_rsp_data;
    logic             b_req_val, b_req_rdy, b_req_we, b_rsp_val, b_rsp_rdy;
    logic [BW-1:0]    b_req_be;
    logic [AW-1:0]    b_req_addr;
    logic [WIDTH-1:0] b_req_data, b_rsp_data;
    logic             sram_en, sram_we;
    logic [BW-1:0]    sram_wbe;
    logic [AW-1:0]    sram_addr;
    logic [WIDTH-1:0] sram_di, sram_do;

    logic [WIDTH-1:0] mem [DEPTH];
    int asserts = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sram_sp_arb #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req_val(a_req_val), .a_req_rdy(a_req_rdy), .a_req_addr(a_req_addr),
        .a_rsp_val(a_rsp_val), .a_rsp_rdy(a_rsp_rdy), .a_rsp_data(a_rsp_data),
        .b_req_val(b_req_val), .b_req_rdy(b_req_rdy), .b_req_we(b_req_we),
        .b_req_be(b_req_be), .b_req_addr(b_req_addr), .b_req_data(b_req_data),
        .b_rsp_val(b_rsp_val), .b_rsp_rdy(b_rsp_rdy), .b_rsp_data(b_rsp_data),
        .sram_en(sram_en), .sram_we(sram_we), .sram_wbe(sram_wbe),
        .sram_addr(sram_addr), .sram_di(sram_di), .sram_do(sram_do)
    );

    // Read-first SRAM: DO shows contents from before a same-cycle write.
    always @(posedge clk) begin
        if (sram_en) begin
            sram_do <= mem[sram_addr];
            if (sram_we)
                for (int i = 0; i < BW; i++)
                    if (sram_wbe[i]) mem[sram_addr][i*8 +: 8] <= sram_di[i*8 +: 8];
        end
    end

    task automatic idle_inputs();
        a_req_val = 0; a_req_addr = '0; a_rsp_rdy = 1;
        b_req_val = 0; b_req_we = 0; b_req_be = '0; b_req_addr = '0; b_req_data = '0; b_rsp_rdy = 1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle_inputs();
        a_req_val = 1; b_req_val = 1;
        @(negedge clk); #1;
        asserts++; if (a_req_rdy !== 1'b0 || b_req_rdy !== 1'b0) begin fails++; $display("FAIL rst_rdy a=%b b=%b want 0", a_req_rdy, b_req_rdy); end
        asserts++; if (sram_en !== 1'b0) begin fails++; $display("FAIL rst_en got %b want 0", sram_en); end
        asserts++; if (a_rsp_val !== 1'b0 || b_rsp_val !== 1'b0) begin fails++; $display("FAIL rst_rspval a=%b b=%b want 0", a_rsp_val, b_rsp_val); end
        asserts++; if (a_rsp_data !== 32'h0 || b_rsp_data !== 32'h0) begin fails++; $display("FAIL rst_data a=%h b=%h want 0", a_rsp_data, b_rsp_data); end
        @(negedge clk);
        rst_n = 1; b_req_val = 0; a_req_addr = 6'd0;
        #1;
        asserts++; if (a_req_rdy !== 1'b1) begin fails++; $display("FAIL rst_agrant got %b want 1", a_req_rdy); end
        @(negedge clk);
        a_req_val = 0; rst_n = 0;
        #1;
        asserts++; if (a_rsp_val !== 1'b0 || a_rsp_data !== 32'h0) begin fails++; $display("FAIL rst_mid val=%b data=%h want 0/0", a_rsp_val, a_rsp_data); end
        asserts++; if (sram_en !== 1'b0) begin fails++; $display("FAIL rst_mid_en got %b want 0", sram_en); end
        @(negedge clk);
        rst_n = 1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); #1;
            asserts++; if (a_rsp_val !== 1'b0) begin fails++; $display("FAIL rst_post%0d a_rsp_val got %b want 0", k, a_rsp_val); end
        end
    endtask

    task automatic test_byte_write();
        idle_inputs();
        @(negedge clk);
        b_req_val = 1; b_req_we = 1; b_req_addr = 6'd5; b_req_data = 32'hAABBCCDD; b_req_be = 4'b1111;
        #1;
        asserts++; if (b_req_rdy !== 1'b1 || sram_we !== 1'b1 || sram_wbe !== 4'b1111) begin fails++; $display("FAIL bw1 rdy=%b we=%b wbe=%b want 1/1/1111", b_req_rdy, sram_we, sram_wbe); end
        @(negedge clk);
        b_req_data = 32'h11223344; b_req_be = 4'b0101;
        #1;
        asserts++; if (b_rsp_val !== 1'b1 || b_rsp_data !== 32'h0) begin fails++; $display("FAIL bw1_ack val=%b data=%h want 1/0", b_rsp_val, b_rsp_data); end
        asserts++; if (sram_wbe !== 4'b0101 || sram_di !== 32'h11223344) begin fails++; $display("FAIL bw2 wbe=%b di=%h want 0101/11223344", sram_wbe, sram_di); end
        @(negedge clk);
        b_req_we = 0; b_req_be = 4'b0000;
        #1;
        asserts++; if (b_rsp_val !== 1'b1 || b_rsp_data !== 32'h0) begin fails++; $display("FAIL bw2_ack val=%b data=%h want 1/0", b_rsp_val, b_rsp_data); end
        asserts++; if (b_req_rdy !== 1'b1 || sram_we !== 1'b0 || sram_wbe !== 4'b0) begin fails++; $display("FAIL brd rdy=%b we=%b wbe=%b want 1/0/0", b_req_rdy, sram_we, sram_wbe); end
        @(negedge clk);
        b_req_val = 0;
        #1;
        asserts++; if (b_rsp_val !== 1'b1 || b_rsp_data !== 32'hAA22CC44) begin fails++; $display("FAIL brd_data val=%b data=%h want 1/aa22cc44", b_rsp_val, b_rsp_data); end
        @(negedge clk); #1;
        asserts++; if (b_rsp_val !== 1'b0) begin fails++; $display("FAIL brd_done got %b want 0", b_rsp_val); end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] exp;
        idle_inputs();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a_req_val = (i < 4);
            a_req_addr = 6'(i);
            #1;
            if (i < 4) begin
                asserts++; if (a_req_rdy !== 1'b1 || sram_addr !== 6'(i)) begin fails++; $display("FAIL b2b_grant%0d rdy=%b addr=%0d want 1/%0d", i, a_req_rdy, sram_addr, i); end
            end
            if (i > 0) begin
                exp = 32'h100 + 32'(i - 1);
                asserts++; if (a_rsp_val !== 1'b1 || a_rsp_data !== exp) begin fails++; $display("FAIL b2b_rsp%0d val=%b data=%h want 1/%h", i, a_rsp_val, a_rsp_data, exp); end
            end
        end
    endtask

    task automatic test_stall();
        idle_inputs();
        @(negedge clk);
        a_req_val = 1; a_req_addr = 6'd7; a_rsp_rdy = 0;
        #1;
        asserts++; if (a_req_rdy !== 1'b1) begin fails++; $display("FAIL st_grant got %b want 1", a_req_rdy); end
        @(negedge clk);
        a_req_addr = 6'd8;
        b_req_val = 1; b_req_we = 1; b_req_be = 4'hF; b_req_addr = 6'd7; b_req_data = 32'hFFFFFFFF;
        #1;
        asserts++; if (a_rsp_val !== 1'b1 || a_rsp_data !== 32'h77) begin fails++; $display("FAIL st_c1 val=%b data=%h want 1/77", a_rsp_val, a_rsp_data); end
        asserts++; if (b_req_rdy !== 1'b1 || a_req_rdy !== 1'b0) begin fails++; $display("FAIL st_c1_rdy b=%b a=%b want 1/0", b_req_rdy, a_req_rdy); end
        for (int k = 2; k < 4; k++) begin
            @(negedge clk);
            b_req_val = 0; b_req_we = 0;
            #1;
            asserts++; if (a_rsp_val !== 1'b1 || a_rsp_data !== 32'h77 || a_req_rdy !== 1'b0) begin fails++; $display("FAIL st_c%0d val=%b data=%h rdy=%b want 1/77/0", k, a_rsp_val, a_rsp_data, a_req_rdy); end
        end
        @(negedge clk);
        a_rsp_rdy = 1;
        #1;
        asserts++; if (a_rsp_val !== 1'b1 || a_rsp_data !== 32'h77 || a_req_rdy !== 1'b0) begin fails++; $display("FAIL st_rel val=%b data=%h rdy=%b want 1/77/0", a_rsp_val, a_rsp_data, a_req_rdy); end
        @(negedge clk); #1;
        asserts++; if (a_rsp_val !== 1'b0 || a_req_rdy !== 1'b1) begin fails++; $display("FAIL st_next val=%b rdy=%b want 0/1", a_rsp_val, a_req_rdy); end
        @(negedge clk);
        a_req_val = 0;
        b_req_val = 1; b_req_addr = 6'd7;
        #1;
        asserts++; if (a_rsp_val !== 1'b1 || a_rsp_data !== 32'h88) begin fails++; $display("FAIL st_a8 val=%b data=%h want 1/88", a_rsp_val, a_rsp_data); end
        @(negedge clk);
        b_req_val = 0;
        #1;
        asserts++; if (b_rsp_data !== 32'hFFFFFFFF) begin fails++; $display("FAIL st_b7 data=%h want ffffffff", b_rsp_data); end
    endtask

    task automatic test_contention();
        logic exp_b;
        idle_inputs();
        @(negedge clk); rst_n = 0;
        @(negedge clk); rst_n = 1;
        a_req_val = 1; a_req_addr = 6'd0;
        b_req_val = 1; b_req_addr = 6'd1;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk);
            #1;
`ifdef SRAM_SP_ARB_RR_EN
            exp_b = (k % 2 == 0);
`else
            exp_b = 1'b1;
`endif
            asserts++; if (b_req_rdy !== exp_b || a_req_rdy !== !exp_b) begin fails++; $display("FAIL cont%0d b=%b a=%b want b=%b", k, b_req_rdy, a_req_rdy, exp_b); end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        for (int i = 0; i < 4; i++) mem[i] = 32'h100 + 32'(i);
        mem[7] = 32'h77;
        mem[8] = 32'h88;
        test_reset();
        test_byte_write();
        test_back_to_back();
        test_stall();
        test_contention();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end
endmodule
